// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory handshake and IF/ID outputs.
// master = the fetch stage itself, slave = its surroundings (hazard unit, decode, imem).
interface fetch_stage_if;
  logic        stall_pc;
  logic        stall_decode;
  logic        pcsrc_decode;
  logic [31:0] branch_target_decode;
  logic        jump_decode;
  logic [31:0] jump_target_decode;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_decode;
  logic [31:0] pcplus4_decode;
  logic        valid_decode;

  modport master (
    input  stall_pc, stall_decode, pcsrc_decode, branch_target_decode,
           jump_decode, jump_target_decode, imem_ready, imem_rdata,
    output imem_req, imem_addr, instr_decode, pcplus4_decode, valid_decode
  );

  modport slave (
    output stall_pc, stall_decode, pcsrc_decode, branch_target_decode,
           jump_decode, jump_target_decode, imem_ready, imem_rdata,
    input  imem_req, imem_addr, instr_decode, pcplus4_decode, valid_decode
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-word skid buffer for stalls, and the IF/ID register.
// Priority each cycle is reset, then stall, then redirect, then normal fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] skid_reg, skid_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pcplus4_reg, pcplus4_next;
  logic        valid_reg, valid_next;

  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        word_avail;
  logic [31:0] word;
  logic [31:0] pc_plus4;

  assign stall      = bus.stall_pc | bus.stall_decode;
  assign redirect   = bus.pcsrc_decode | bus.jump_decode;
  assign target     = bus.pcsrc_decode ? bus.branch_target_decode : bus.jump_target_decode;
  assign word_avail = (state_reg == HOLD) | bus.imem_ready;
  assign word       = (state_reg == HOLD) ? skid_reg : bus.imem_rdata;
  assign pc_plus4   = pc_reg + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      skid_reg    <= 32'd0;
      instr_reg   <= 32'd0;
      pcplus4_reg <= 32'd0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      skid_reg    <= skid_next;
      instr_reg   <= instr_next;
      pcplus4_reg <= pcplus4_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    skid_next    = skid_reg;
    instr_next   = instr_reg;
    pcplus4_next = pcplus4_reg;
    valid_next   = valid_reg;

    if (stall) begin
      // A word arriving during a stall is parked so it is not refetched later.
      if (state_reg == FETCH && bus.imem_ready) begin
        skid_next  = bus.imem_rdata;
        state_next = HOLD;
      end
    end else if (redirect) begin
      pc_next      = {target[31:2], 2'b00};
      instr_next   = 32'd0;
      pcplus4_next = 32'd0;
      valid_next   = 1'b0;
      skid_next    = 32'd0;
      state_next   = FETCH;
    end else if (word_avail) begin
      instr_next   = word;
      pcplus4_next = pc_plus4;
      valid_next   = 1'b1;
      pc_next      = pc_plus4;
      state_next   = FETCH;
    end else begin
      instr_next   = 32'd0;
      pcplus4_next = 32'd0;
      valid_next   = 1'b0;
    end
  end

  always_comb begin
    bus.imem_req       = (state_reg == FETCH);
    bus.imem_addr      = pc_reg;
    bus.instr_decode   = instr_reg;
    bus.pcplus4_decode = pcplus4_reg;
    bus.valid_decode   = valid_reg;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a word-level model of the fetch rules is compared every
// cycle, and literal expectations pin the scenarios down independently of that model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cycle_no    = 0;
  bit cmp_en      = 1'b0;

  // Model: program counter, an optional parked word, and what decode should be holding.
  logic [31:0] m_pc, m_park_word, m_instr, m_pc4;
  logic        m_parked, m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RESET_PC; m_parked <= 1'b0; m_park_word <= 32'd0;
      m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
    end else if (bus.stall_pc || bus.stall_decode) begin
      if (!m_parked && bus.imem_ready) begin
        m_parked    <= 1'b1;
        m_park_word <= bus.imem_rdata;
      end
    end else if (bus.pcsrc_decode || bus.jump_decode) begin
      m_pc     <= (bus.pcsrc_decode ? bus.branch_target_decode : bus.jump_target_decode) & ~32'h3;
      m_instr  <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
      m_parked <= 1'b0;
    end else if (m_parked || bus.imem_ready) begin
      m_instr  <= m_parked ? m_park_word : bus.imem_rdata;
      m_pc4    <= m_pc + 32'd4;
      m_valid  <= 1'b1;
      m_pc     <= m_pc + 32'd4;
      m_parked <= 1'b0;
    end else begin
      m_instr <= 32'd0; m_pc4 <= 32'd0; m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      cycle_no++;
      vectors++;
      $display("cyc %0d: req=%0b addr=%h instr=%h pc4=%h valid=%0b", cycle_no,
               bus.imem_req, bus.imem_addr, bus.instr_decode, bus.pcplus4_decode, bus.valid_decode);
      if (bus.imem_req !== !m_parked || bus.imem_addr !== m_pc || bus.instr_decode !== m_instr ||
          bus.pcplus4_decode !== m_pc4 || bus.valid_decode !== m_valid) begin
        miscompares++;
        $display("FAIL model cyc %0d: got req=%0b addr=%h instr=%h pc4=%h valid=%0b want req=%0b addr=%h instr=%h pc4=%h valid=%0b",
                 cycle_no, bus.imem_req, bus.imem_addr, bus.instr_decode, bus.pcplus4_decode,
                 bus.valid_decode, !m_parked, m_pc, m_instr, m_pc4, m_valid);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return just after the following falling edge.
  task automatic cyc(input logic sp, input logic sd, input logic pcs, input logic [31:0] bt,
                     input logic jmp, input logic [31:0] jt, input logic rdy, input logic [31:0] rd);
    bus.stall_pc = sp; bus.stall_decode = sd;
    bus.pcsrc_decode = pcs; bus.branch_target_decode = bt;
    bus.jump_decode = jmp; bus.jump_target_decode = jt;
    bus.imem_ready = rdy; bus.imem_rdata = rd;
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic rdy, input logic [31:0] rd);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy, rd);
  endtask

  task automatic jump_to(input logic [31:0] t);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, t, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall_pc = 1'b0; bus.stall_decode = 1'b0;
    bus.pcsrc_decode = 1'b0; bus.branch_target_decode = 32'd0;
    bus.jump_decode = 1'b0; bus.jump_target_decode = 32'd0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {31'd0, bus.valid_decode}, 32'd0);
    chk("reset_instr", bus.instr_decode, 32'd0);
    chk("reset_pc4", bus.pcplus4_decode, 32'd0);
    chk("reset_addr", bus.imem_addr, RESET_PC);
    chk("reset_req", {31'd0, bus.imem_req}, 32'd1);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Back-to-back fetch from reset
    fetch(1'b1, 32'h11);
    chk("seq1_instr", bus.instr_decode, 32'h11);
    chk("seq1_pc4", bus.pcplus4_decode, 32'd4);
    fetch(1'b1, 32'h22);
    chk("seq2_instr", bus.instr_decode, 32'h22);
    chk("seq2_pc4", bus.pcplus4_decode, 32'd8);
    fetch(1'b1, 32'h33);
    chk("seq3_instr", bus.instr_decode, 32'h33);
    chk("seq3_pc4", bus.pcplus4_decode, 32'd12);
    chk("seq3_valid", {31'd0, bus.valid_decode}, 32'd1);

    // Slow memory at PC=8
    jump_to(32'h8);
    for (int i = 0; i < 3; i++) begin
      fetch(1'b0, 32'hBAD);
      chk("wait_valid", {31'd0, bus.valid_decode}, 32'd0);
      chk("wait_addr", bus.imem_addr, 32'h8);
    end
    fetch(1'b1, 32'h44);
    chk("wait_done_instr", bus.instr_decode, 32'h44);
    chk("wait_done_pc4", bus.pcplus4_decode, 32'd12);

    // Stall while the word at PC=4 returns
    jump_to(32'h0);
    fetch(1'b1, 32'h55);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hAA);
    chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    chk("stall_instr", bus.instr_decode, 32'h55);
    cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hBB);
    chk("stall2_req", {31'd0, bus.imem_req}, 32'd0);
    chk("stall2_pc4", bus.pcplus4_decode, 32'd4);
    fetch(1'b0, 32'd0);
    chk("unstall_instr", bus.instr_decode, 32'hAA);
    chk("unstall_addr", bus.imem_addr, 32'h8);

    // Taken branch to an unaligned target
    cyc(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'd0, 1'b1, 32'hDEAD);
    chk("branch_addr", bus.imem_addr, 32'h100);
    chk("branch_valid", {31'd0, bus.valid_decode}, 32'd0);
    fetch(1'b1, 32'h66);
    chk("branch_instr", bus.instr_decode, 32'h66);
    chk("branch_pc4", bus.pcplus4_decode, 32'h104);

    // Branch and jump together while stalled, then released
    cyc(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'd0);
    chk("redir_stall_addr", bus.imem_addr, 32'h104);
    cyc(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h77);
    chk("redir_stall_instr", bus.instr_decode, 32'h66);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h40);
    fetch(1'b1, 32'h88);
    chk("redir_instr", bus.instr_decode, 32'h88);
    chk("redir_pc4", bus.pcplus4_decode, 32'h44);

    // PC wrap at the top of the address space
    jump_to(32'hFFFF_FFFC);
    fetch(1'b1, 32'h99);
    chk("wrap_pc4", bus.pcplus4_decode, 32'd0);
    chk("wrap_addr", bus.imem_addr, 32'd0);
    fetch(1'b1, 32'hA1);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hCC);
    chk("hold_addr", bus.imem_addr, 32'h4);

    // Asynchronous reset while a word is parked
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.valid_decode}, 32'd0);
    chk("arst_addr", bus.imem_addr, RESET_PC);
    chk("arst_req", {31'd0, bus.imem_req}, 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    fetch(1'b1, 32'h12);
    chk("post_rst_instr", bus.instr_decode, 32'h12);
    chk("post_rst_pc4", bus.pcplus4_decode, 32'd4);
    fetch(1'b0, 32'd0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
